// File: rtl/filt_round_fifo.sv
// filt_round_fifo: gain shift, convergent rounding, overflow handling, output FIFO.
// Optional clamp on overflow: define FILT_ROUND_SATURATE_EN (default build wraps).
module filt_round_fifo #(
  parameter int IW     = 39,
  parameter int OW     = 16,
  parameter int SHIFT  = 0,
  parameter int LGFLEN = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_ce,
  input  logic [IW-1:0]     i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OW-1:0]     o_data,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_clip,
  output logic              o_ovf,
  input  logic              i_ovf_clr
);

  // Dropped LSB count, rounding word width, FIFO depth.
  localparam int L     = IW - SHIFT - OW;
  localparam int RW    = OW + SHIFT + 1;
  localparam int DEPTH = 1 << LGFLEN;
  localparam int HW    = SHIFT + 2;

  localparam logic [L-1:0]  HALF = L'(1) << (L - 1);
  localparam logic [OW-1:0] MAXV = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] MINV = {1'b1, {(OW-1){1'b0}}};

  // Stage 1 state
  logic          v1_q;
  logic [RW-1:0] r1_q;
  logic [RW-1:0] r1_d;

  // Stage 2 state
  logic          v2_q;
  logic [OW-1:0] d2_q;
  logic [OW-1:0] d2_d;
  logic          clip_q;
  logic          ovf2_w;

  // FIFO state
  logic [OW-1:0] mem_q [DEPTH];
  logic [LGFLEN:0] wptr_q, wptr_d;
  logic [LGFLEN:0] rptr_q, rptr_d;
  logic          sov_q, sov_d;

  logic [RW-2:0] keep_w;
  logic [L-1:0]  drop_w;
  logic          rnd_w;
  logic [HW-1:0] hi_w;
  logic          empty_w;
  logic          full_w;
  logic          pop_w;
  logic          push_w;
  logic          lost_w;

  // Round-half-to-even on the upper bits, one guard bit keeps the carry.
  always_comb begin
    keep_w = i_data[IW-1:L];
    drop_w = i_data[L-1:0];
    rnd_w  = (drop_w > HALF) |
             ((drop_w == HALF) & keep_w[0]);
    r1_d   = {keep_w[RW-2], keep_w} +
             {{(RW-1){1'b0}}, rnd_w};
  end

  // Stage 1 register: rounded word.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      v1_q <= 1'b0;
      r1_q <= '0;
    end else begin
      v1_q <= i_ce;
      if (i_ce) r1_q <= r1_d;
    end
  end

  // Overflow when the bits above the OW-bit sign are not a sign extension.
  always_comb begin
    hi_w   = r1_q[RW-1:OW-1];
    ovf2_w = ~((&hi_w) | (~|hi_w));
`ifdef FILT_ROUND_SATURATE_EN
    if (ovf2_w) d2_d = r1_q[RW-1] ? MINV : MAXV;
    else        d2_d = r1_q[OW-1:0];
`else
    d2_d = r1_q[OW-1:0];
`endif
  end

  // Stage 2 register: resolved OW-bit sample and clip pulse.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      v2_q   <= 1'b0;
      d2_q   <= '0;
      clip_q <= 1'b0;
    end else begin
      v2_q   <= v1_q;
      clip_q <= v1_q & ovf2_w;
      if (v1_q) d2_q <= d2_d;
    end
  end

  // FIFO control: a push into a full FIFO survives only with a same-edge pop.
  always_comb begin
    empty_w = (wptr_q == rptr_q);
    full_w  = (wptr_q[LGFLEN] != rptr_q[LGFLEN]) &&
              (wptr_q[LGFLEN-1:0] == rptr_q[LGFLEN-1:0]);
    pop_w   = ~empty_w & i_ready;
    push_w  = v2_q & (~full_w | pop_w);
    lost_w  = v2_q & full_w & ~pop_w;
    wptr_d  = wptr_q + {{LGFLEN{1'b0}}, push_w};
    rptr_d  = rptr_q + {{LGFLEN{1'b0}}, pop_w};
    sov_d   = sov_q;
    if (lost_w)         sov_d = 1'b1;
    else if (i_ovf_clr) sov_d = 1'b0;
  end

  // Pointer and sticky-drop registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      sov_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      sov_q  <= sov_d;
    end
  end

  // Sample storage; contents are only observed through the valid head.
  always_ff @(posedge i_clk) begin
    if (push_w) mem_q[wptr_q[LGFLEN-1:0]] <= d2_q;
  end

  assign o_valid = ~empty_w;
  assign o_data  = empty_w ? '0 : mem_q[rptr_q[LGFLEN-1:0]];
  assign o_fill  = wptr_q - rptr_q;
  assign o_clip  = clip_q;
  assign o_ovf   = sov_q;

endmodule

// File: tb/tb_filt_round_fifo.sv
// tb_filt_round_fifo: directed vectors plus an arithmetic reference model.
// Model rounds with integer math and tracks the FIFO as a queue.
module tb_filt_round_fifo;
  localparam int IW = 39;
  localparam int OW = 16;
  localparam int SHIFT = 0;
  localparam int LGFLEN = 2;
  localparam int DEPTH = 4;
  localparam int L = IW - SHIFT - OW;

  logic i_clk = 0;
  logic i_reset_n = 1;
  logic i_ce = 0;
  logic i_ready = 0;
  logic i_ovf_clr = 0;
  logic [IW-1:0] i_data = '0;
  logic o_valid;
  logic [OW-1:0] o_data;
  logic [LGFLEN:0] o_fill;
  logic o_clip;
  logic o_ovf;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  always #5 i_clk = ~i_clk;

  filt_round_fifo #(
    .IW(IW), .OW(OW), .SHIFT(SHIFT), .LGFLEN(LGFLEN)
  ) dut (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .i_ce(i_ce),
    .i_data(i_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data(o_data),
    .o_fill(o_fill),
    .o_clip(o_clip),
    .o_ovf(o_ovf),
    .i_ovf_clr(i_ovf_clr)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: R = round_half_even(x / 2^L), then range check.
  function automatic void ref_round(input logic [IW-1:0] din,
                                    output logic [OW-1:0] dout,
                                    output bit clip);
    longint x, q, rem, one;
    x = longint'($signed(din));
    one = longint'(1) << L;
    q = x >>> L;
    rem = x - q * one;
    if (rem > one / 2 || (rem == one / 2 && (q & 1) != 0))
      q++;
    clip = (q > 2 ** (OW - 1) - 1) || (q < -(2 ** (OW - 1)));
`ifdef FILT_ROUND_SATURATE_EN
    if (clip) dout = (q < 0) ? 16'h8000 : 16'h7FFF;
    else dout = OW'(q);
`else
    dout = OW'(q);
`endif
  endfunction

  logic [OW-1:0] mq[$];
  bit ms1_v, ms2_v, ms1_c;
  logic [OW-1:0] ms1_d, ms2_d;
  bit mclip, movf;
  bit m_pop, m_drop;

  // Model: two delay slots, then queue with depth limit.
  initial forever begin
    @(posedge i_clk or negedge i_reset_n);
    if (!i_reset_n) begin
      mq.delete();
      ms1_v = 0; ms2_v = 0; mclip = 0; movf = 0;
    end else begin
      m_pop = (mq.size() != 0) && i_ready;
      m_drop = 0;
      if (m_pop) void'(mq.pop_front());
      if (ms2_v) begin
        if (mq.size() < DEPTH) mq.push_back(ms2_d);
        else m_drop = 1;
      end
      if (m_drop) movf = 1;
      else if (i_ovf_clr) movf = 0;
      mclip = ms1_v && ms1_c;
      ms2_v = ms1_v;
      ms2_d = ms1_d;
      ms1_v = i_ce;
      if (i_ce) ref_round(i_data, ms1_d, ms1_c);
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge i_clk);
    if (chk_en) begin
      chk("m_valid", o_valid, mq.size() != 0);
      chk("m_fill", o_fill, mq.size());
      if (mq.size() != 0) chk("m_data", o_data, mq[0]);
      chk("m_clip", o_clip, mclip);
      chk("m_ovf", o_ovf, movf);
    end
  end

  // One sample through an empty pipe with i_ready=1; pins 3-clock latency.
  task automatic send_one(input string nm,
                          input logic [IW-1:0] d,
                          input logic [OW-1:0] exp,
                          input bit expclip);
    i_ce = 1; i_data = d;
    @(negedge i_clk); i_ce = 0;
    @(negedge i_clk);
    chk({nm, "_clip"}, o_clip, expclip);
    chk({nm, "_early"}, o_valid, 0);
    @(negedge i_clk);
    chk({nm, "_valid"}, o_valid, 1);
    chk({nm, "_data"}, o_data, exp);
    @(negedge i_clk);
    chk({nm, "_popped"}, o_valid, 0);
  endtask

  task automatic burst(input int base, input int n);
    for (int k = 1; k <= n; k++) begin
      i_ce = 1;
      i_data = IW'(base + k) << L;
      @(negedge i_clk);
    end
    i_ce = 0;
  endtask

  int stale;

  initial begin
    #1 i_reset_n = 0;
    repeat (2) @(negedge i_clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_fill", o_fill, 0);
    chk("rst_clip", o_clip, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_data", o_data, 0);
    chk_en = 1;
    @(posedge i_clk); #2 i_reset_n = 1;
    @(negedge i_clk);
    i_ready = 1;

    send_one("rnd_c0", 39'h0000C00000, 16'h0002, 0);
    send_one("rnd_40", 39'h0000400000, 16'h0000, 0);
    send_one("rnd_50", 39'h0000500000, 16'h0001, 0);
    send_one("rnd_n4", 39'h7FFFC00000, 16'h0000, 0);
    send_one("rnd_nc", 39'h7FFF400000, 16'hFFFE, 0);
`ifdef FILT_ROUND_SATURATE_EN
    send_one("clip_pos", 39'h3FFFFFFFFF, 16'h7FFF, 1);
`else
    send_one("clip_pos", 39'h3FFFFFFFFF, 16'h8000, 1);
`endif
    send_one("min_neg", 39'h4000000000, 16'h8000, 0);

    // Back-pressure: six samples, only four fit.
    i_ready = 0;
    burst(0, 6);
    repeat (3) @(negedge i_clk);
    chk("bp_fill", o_fill, 4);
    chk("bp_ovf", o_ovf, 1);
    for (int k = 1; k <= 4; k++) begin
      chk("bp_drain", o_data, k);
      i_ready = 1;
      @(negedge i_clk);
    end
    chk("bp_empty_v", o_valid, 0);
    chk("bp_empty_f", o_fill, 0);

    // Clear alone.
    i_ovf_clr = 1;
    @(negedge i_clk);
    i_ovf_clr = 0;
    chk("clr_alone", o_ovf, 0);

    // Full FIFO, pop on the same edge as the fifth push.
    i_ready = 0;
    burst(16, 5);
    @(negedge i_clk);
    chk("fp_fill4", o_fill, 4);
    i_ready = 1;
    @(negedge i_clk);
    i_ready = 0;
    chk("fp_fill_keep", o_fill, 4);
    chk("fp_no_ovf", o_ovf, 0);
    for (int k = 2; k <= 5; k++) begin
      chk("fp_drain", o_data, 16 + k);
      i_ready = 1;
      @(negedge i_clk);
    end
    chk("fp_empty", o_valid, 0);

    // Clear and drop on the same edge: set wins.
    i_ready = 0;
    burst(32, 5);
    @(negedge i_clk);
    i_ovf_clr = 1;
    @(negedge i_clk);
    chk("clr_vs_drop", o_ovf, 1);
    @(negedge i_clk);
    i_ovf_clr = 0;
    chk("clr_after", o_ovf, 0);
    for (int k = 1; k <= 4; k++) begin
      chk("cd_drain", o_data, 32 + k);
      i_ready = 1;
      @(negedge i_clk);
    end

    // Reset with 3 queued and 2 in flight.
    i_ready = 0;
    burst(48, 5);
    chk("mr_fill3", o_fill, 3);
    #2 i_reset_n = 0;
    #1;
    chk("mr_valid", o_valid, 0);
    chk("mr_fill", o_fill, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      i_ce = 1;
      i_data = IW'(60 + k) << L;
    end
    @(negedge i_clk);
    i_ce = 0;
    @(posedge i_clk); #2 i_reset_n = 1;
    i_ready = 1;
    stale = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (o_valid) stale++;
    end
    chk("mr_stale", stale, 0);

    // Mixed traffic checked by the model.
    for (int c = 0; c < 400; c++) begin
      i_ce = $urandom_range(0, 1) != 0;
      i_data = IW'({$urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0)
        i_data = IW'($urandom()) << $urandom_range(0, 22);
      i_ready = $urandom_range(0, 3) != 0;
      i_ovf_clr = $urandom_range(0, 15) == 0;
      @(negedge i_clk);
    end
    i_ce = 0;
    i_ovf_clr = 0;
    i_ready = 1;
    repeat (10) @(negedge i_clk);
    chk("end_empty", o_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/filt_round_fifo.md
Name: filt_round_fifo

Overview:
- Output conditioning stage that sits directly downstream of the single-multiplier slow filter.
- Accepts the filter's full-precision accumulator word on each output strobe.
- Applies a fixed gain shift, convergent (round-half-to-even) rounding and overflow handling to reduce the word to OW bits.
- Buffers results in a small FIFO with a valid/ready handshake, so a back-pressuring consumer can take samples at its own pace.

Parameters:
- IW, 39: input width; matches the filter accumulator width (16+16+7).
- OW, 16: output width.
- SHIFT, 0: number of input MSBs discarded as gain. Kept field is bits [IW-1-SHIFT -: OW]. Requires SHIFT+OW < IW, i.e. at least 1 LSB is rounded away.
- LGFLEN, 2: log2 of FIFO depth (depth 4).

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_ce  in  1  input sample strobe (filter o_ce)
- i_data  in  IW  signed input sample (filter o_result)
- o_valid  out  1  FIFO non-empty; o_data valid
- i_ready  in  1  consumer accepts o_data this cycle
- o_data  out  OW  signed rounded result at FIFO head
- o_fill  out  LGFLEN+1  current FIFO occupancy, 0..2^LGFLEN
- o_clip  out  1  one-cycle pulse: a sample overflowed OW bits
- o_ovf  out  1  sticky: a sample was dropped because the FIFO was full
- i_ovf_clr  in  1  synchronous clear of o_ovf

Behaviour:
- Reset (async assert, sync release): all pipeline valids = 0, FIFO pointers = 0, o_valid = 0, o_fill = 0, o_clip = 0, o_ovf = 0, o_data = 0.
- Define L = IW-SHIFT-OW (dropped LSBs), K = kept field, D = dropped field, H = 1<<(L-1).
- Stage 1 (edge 1 after i_ce):
  - if D > H: round up, R = K+1.
  - if D == H: R = K + K[0] (round half to even).
  - if D < H: R = K.
  - R is computed at width OW+SHIFT+1 (sign-extended upper bits included) so the carry is never lost.
  - Negative values round on two's-complement bits, so -0.5 LSB becomes 0.
- Stage 2 (edge 2): overflow when R is outside [-2^(OW-1), 2^(OW-1)-1]. Resolution of R to OW bits is set by the optional feature below. o_clip pulses high for exactly one cycle aligned with this stage.
- Stage 3 (edge 3): push into FIFO. With the FIFO previously empty, o_valid is high in the cycle after edge 3, i.e. latency 3 clocks.
- Pipeline accepts i_ce on every cycle: fully pipelined, no stall, no input-side back-pressure.
- Pop: occurs when o_valid && i_ready at the rising edge. o_data is the head entry and is read combinationally from FIFO memory.
- Push into a full FIFO:
  - accepted if a pop occurs on the same edge;
  - otherwise the sample is discarded, FIFO contents are unchanged, and o_ovf is set.
- Simultaneous push and pop: o_fill is unchanged; both pointers advance. Pointer wrap is modulo 2^LGFLEN; full/empty is distinguished by an extra pointer MSB.
- i_ready while empty: ignored; no pointer movement.
- o_ovf is cleared by i_ovf_clr. If i_ovf_clr and a new drop occur on the same edge, set wins.
- i_ce during reset is ignored. Deasserting reset mid-stream drops all in-flight samples.

Optional Feature:
- Macro: FILT_ROUND_SATURATE_EN.
- Defined: an overflowing R is clamped to 2^(OW-1)-1 or -2^(OW-1), according to the sign of R.
- Undefined: R is truncated to its low OW bits (two's-complement wrap).
- o_clip behaves identically in both builds.

Test Plan:
- Rounding, IW=39, OW=16, SHIFT=0, i_ready=1, one i_ce each:
  - 0x0000C00000 → o_data 0x0002
  - 0x0000400000 → 0x0000
  - 0x0000500000 → 0x0001
  - -0x400000 → 0x0000
  - -0xC00000 → 0xFFFE
  - Each appears exactly 3 clocks after its i_ce.
- Clip: i_data 0x3FFFFFFFFF → o_clip pulse; o_data 0x7FFF with FILT_ROUND_SATURATE_EN, 0x8000 without. i_data 0x4000000000 → no clip, o_data 0x8000.
- Back-pressure: i_ready=0, 6 consecutive i_ce → o_fill reaches 4, o_ovf=1. Then i_ready=1 → exactly the first 4 samples drain in order, o_valid drops, o_fill=0.
- Full with simultaneous pop: FIFO holding 4 entries, i_ready=1 on the edge a 5th push arrives → no drop, o_ovf stays 0, o_fill stays 4.
- Reset mid-stream: assert i_reset_n=0 with 2 samples in the pipeline and 3 in the FIFO → o_valid=0, o_fill=0 immediately (async). After release, no stale samples ever appear.
- i_ovf_clr asserted on the same edge as a new drop → o_ovf remains 1. i_ovf_clr alone on the next edge → o_ovf=0.
